mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single memory_unit port between the two issue lanes of the superscalar core. It accepts one request packet per lane over valid/ready handshakes and preserves in-group program order, with lane 0 older than lane 1. It registers the granted packet toward memory_unit and steers the one-cycle-later register writeback to the owning lane.

## Interface
Parameters:
- AW, 5: memory address width.
- DW, 16: data / value width.
- RW, 3: register address width.
- PKT_W, AW+DW+RW+3 (27): packet width; layout {addr, value, reg, is_load, is_mem_write, is_write}, MSB first.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_0  in  1  lane 0 request valid; held until accepted.
- req_pkt_0  in  PKT_W  lane 0 packet; stable while valid.
- req_ready_0  out  1  lane 0 accept.
- req_valid_1, req_pkt_1, req_ready_1: same as lane 0, for lane 1.
- mem_req_valid  out  1  registered request to memory_unit.
- mem_req_pkt  out  PKT_W  registered packet to memory_unit.
- mem_ready  in  1  memory_unit accepts the request this cycle.
- mem_wb_valid  in  1  memory_unit writeback valid.
- mem_wb_reg  in  RW  writeback destination register.
- mem_wb_data  in  DW  writeback data: load result, or value if not a load.
- wb_valid_0  out  1  writeback belongs to lane 0.
- wb_valid_1  out  1  writeback belongs to lane 1.
- wb_reg  out  RW  forwarded mem_wb_reg.
- wb_data  out  DW  forwarded mem_wb_data.
- wb_err  out  1  sticky: writeback arrived with no matching tag.

## Operation
Output stage:
- out_free = !mem_req_valid | mem_ready.
- A lane accept loads {mem_req_valid=1, mem_req_pkt=req_pkt_x}.
- When out_free is true and no accept occurs, mem_req_valid clears.
- When out_free is false, the output register holds unchanged.

FSM, 2 states:
- OPEN:
  - req_ready_0 = out_free.
  - req_ready_1 = out_free & !req_valid_0.
  - Both valid and out_free: grant lane 0, go to L1_PEND.
  - Only one lane valid: grant it, stay in OPEN.
- L1_PEND:
  - req_ready_0 = 0.
  - req_ready_1 = out_free.
  - Lane 1 accepted: return to OPEN.
  - Lane 0 cannot be granted again until lane 1 has been served (no starvation, order kept).
- Dropping req_valid_1 while in L1_PEND is a protocol violation; the block stays in L1_PEND.

Tag tracking:
- On each memory handshake (mem_req_valid & mem_ready), capture tag_v = pkt.is_write and tag_lane = granted lane of that packet.
- Otherwise clear tag_v.

Writeback steering (combinational):
- wb_valid_0 = mem_wb_valid & tag_v & (tag_lane==0).
- wb_valid_1 = mem_wb_valid & tag_v & (tag_lane==1).
- wb_reg and wb_data pass through unmodified.
- mem_wb_valid & !tag_v: sets wb_err; the writeback is dropped (both wb_valid low).
- wb_err clears only on reset.

Packets pass through bit-exact; the arbiter performs no arithmetic on packet fields.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=OPEN, mem_req_valid=0, mem_req_pkt=0, tag_v=0, tag_lane=0, wb_err=0.
  - Consequently req_ready_0=1, and req_ready_1=!req_valid_0.
- Request latency: accept at edge N; mem_req_valid is high after edge N.
- Throughput: one accepted request per cycle while mem_ready=1.
- Writeback: the memory handshake at edge M produces mem_wb_valid in cycle M+1, steered combinationally in the same cycle.
- Stall: mem_ready=0 holds mem_req_pkt, both readies are 0, and FSM state is held.
- Simultaneous events:
  - A handshake and a new accept in the same cycle replace the output register with no bubble.
  - A tag capture and an incoming writeback in the same cycle use the old tag for steering.
- Reset mid-operation:
  - A pending output is discarded and L1_PEND is abandoned.
  - A writeback in the first cycle after reset sets wb_err.

## Test plan
- Lane 0 alone: pkt {addr=5, value=ABCD, reg=1, 0,1,1}, mem_ready=1 -> mem_req_valid in cycle 1 with exact pkt; a writeback {reg=1, data=ABCD} next cycle gives wb_valid_0=1, wb_valid_1=0.
- Both lanes valid in the same cycle:
  - Stimulus: lane 0 store addr 2 value 1234; lane 1 load addr 2 reg 2.
  - Response: lane 0 is issued first, then lane 1.
  - req_ready_0=0 during L1_PEND.
  - The lane 1 writeback sets wb_valid_1.
- Continuous both-valid for 6 cycles -> issue order strictly 0,1,0,1,0,1, with no lane granted twice in a row.
- mem_ready=0 for 3 cycles with a pending packet -> mem_req_pkt stable, both readies 0; resume issues the next packet with no bubble.
- Packet with is_write=0 (pure store) -> tag_v=0; a forced mem_wb_valid the next cycle sets wb_err=1 and keeps both wb_valid=0.
- Assert rst_n=0 during L1_PEND with mem_req_valid=1 -> all outputs reach their reset values immediately; after release the FSM is OPEN and req_ready_1=1 when lane 0 is idle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory_unit request port between the two issue lanes of
// the superscalar core. Lane 0 holds the older instruction of an issue group,
// so when both lanes ask in the same cycle lane 0 goes first. Lane 1 is then
// guaranteed the very next slot before lane 0 may be granted again. The granted
// packet is registered toward memory_unit. The writeback that returns one
// cycle after each memory handshake is steered back to the lane that owned
// that packet.
//
// Packet layout (MSB first): {addr, value, reg, is_load, is_mem_write, is_write}
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_x / req_pkt_x        lane x request (held until accepted)
//   req_ready_x                    lane x accept
//   mem_req_valid / mem_req_pkt    registered request toward memory_unit
//   mem_ready                      memory_unit takes the request this cycle
//   mem_wb_valid/_reg/_data        writeback from memory_unit
//   wb_valid_0 / wb_valid_1        writeback ownership, combinational
//   wb_reg / wb_data               writeback register and data, passed through
//   wb_err                         sticky: a writeback arrived with no live tag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int RW    = 3,
    parameter int PKT_W = AW + DW + RW + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic [PKT_W-1:0] req_pkt_0,
    output logic             req_ready_0,
    input  logic             req_valid_1,
    input  logic [PKT_W-1:0] req_pkt_1,
    output logic             req_ready_1,
    output logic             mem_req_valid,
    output logic [PKT_W-1:0] mem_req_pkt,
    input  logic             mem_ready,
    input  logic             mem_wb_valid,
    input  logic [RW-1:0]    mem_wb_reg,
    input  logic [DW-1:0]    mem_wb_data,
    output logic             wb_valid_0,
    output logic             wb_valid_1,
    output logic [RW-1:0]    wb_reg,
    output logic [DW-1:0]    wb_data,
    output logic             wb_err
);

    // is_write is the least significant packet field
    localparam int IS_WRITE_BIT = 0;

    // ST_L1_PEND: lane 0 of a two-request group was granted and lane 1 is owed
    // the next slot.
    typedef enum logic [0:0] {
        ST_OPEN    = 1'b0,
        ST_L1_PEND = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               mem_req_valid_r;
    logic [PKT_W-1:0]   mem_req_pkt_r;
    logic               out_lane_r;      // lane that owns the packet in the output register
    logic               tag_v_r;
    logic               tag_lane_r;
    logic               wb_err_r;
    logic               out_free_s;
    logic               ready_0_s;
    logic               ready_1_s;
    logic               accept_0_s;
    logic               accept_1_s;
    logic               mem_hs_s;

    // The output register can take a new packet when it is empty or draining.
    assign out_free_s = !mem_req_valid_r | mem_ready;
    assign mem_hs_s   = mem_req_valid_r & mem_ready;

    // Ready generation and next-state selection for the lane ordering FSM.
    always_comb begin
        ready_0_s   = 1'b0;
        ready_1_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_OPEN: begin
                ready_0_s = out_free_s;
                // Lane 1 must wait behind an older lane 0 request.
                ready_1_s = out_free_s & !req_valid_0;
                if (out_free_s & req_valid_0 & req_valid_1) begin
                    state_nxt_s = ST_L1_PEND;
                end else begin
                    state_nxt_s = ST_OPEN;
                end
            end
            ST_L1_PEND: begin
                ready_0_s = 1'b0;
                ready_1_s = out_free_s;
                // If lane 1 drops valid here, the owed slot is kept for it.
                if (out_free_s & req_valid_1) begin
                    state_nxt_s = ST_OPEN;
                end else begin
                    state_nxt_s = ST_L1_PEND;
                end
            end
            default: begin
                ready_0_s   = 1'b0;
                ready_1_s   = 1'b0;
                state_nxt_s = ST_OPEN;
            end
        endcase
    end

    assign accept_0_s  = req_valid_0 & ready_0_s;
    assign accept_1_s  = req_valid_1 & ready_1_s;
    assign req_ready_0 = ready_0_s;
    assign req_ready_1 = ready_1_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OPEN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register toward memory_unit. It is replaced on accept, emptied
    // when free with no accept, and held during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid_r <= 1'b0;
            mem_req_pkt_r   <= {PKT_W{1'b0}};
            out_lane_r      <= 1'b0;
        end else if (accept_0_s) begin
            mem_req_valid_r <= 1'b1;
            mem_req_pkt_r   <= req_pkt_0;
            out_lane_r      <= 1'b0;
        end else if (accept_1_s) begin
            mem_req_valid_r <= 1'b1;
            mem_req_pkt_r   <= req_pkt_1;
            out_lane_r      <= 1'b1;
        end else if (out_free_s) begin
            mem_req_valid_r <= 1'b0;
        end else begin
            mem_req_valid_r <= mem_req_valid_r;
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_pkt   = mem_req_pkt_r;

    // Tag for the writeback expected next cycle. It is live only after a
    // handshake of a packet with is_write set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r    <= 1'b0;
            tag_lane_r <= 1'b0;
        end else if (mem_hs_s) begin
            tag_v_r    <= mem_req_pkt_r[IS_WRITE_BIT];
            tag_lane_r <= out_lane_r;
        end else begin
            tag_v_r    <= 1'b0;
        end
    end

    // Sticky flag for a writeback with no live tag. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_r <= 1'b0;
        end else if (mem_wb_valid & !tag_v_r) begin
            wb_err_r <= 1'b1;
        end else begin
            wb_err_r <= wb_err_r;
        end
    end

    // Steering uses the tag registered at the previous handshake, so a capture
    // at this edge does not affect the writeback of this cycle.
    assign wb_valid_0 = mem_wb_valid & tag_v_r & !tag_lane_r;
    assign wb_valid_1 = mem_wb_valid & tag_v_r & tag_lane_r;
    assign wb_reg     = mem_wb_reg;
    assign wb_data    = mem_wb_data;
    assign wb_err     = wb_err_r;

endmodule
